fft_input_buffer: RTL and testbench



---
 rtl/fft_pkg.sv | 22 ++
 rtl/fft_input_buffer_if.sv | 32 +++
 rtl/fft_bank_ram.sv | 45 ++++
 rtl/fft_input_buffer.sv | 115 +++++++++++
 tb/tb_fft_input_buffer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, read-side states and bit-reversal helper for the FFT front end
package fft_pkg;

  localparam int NPT        = 64;
  localparam int ADDR_W     = 6;
  localparam int DW_DEFAULT = 16;

  typedef enum logic {
    RD_EMPTY = 1'b0,
    RD_FULL  = 1'b1
  } rd_state_e;

  // Bit i of the natural index lands on bit 5-i of the storage address.
  function automatic logic [ADDR_W-1:0] bitrev6(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) begin
      r[i] = a[ADDR_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_input_buffer_if.sv
// rtl/fft_input_buffer_if.sv - sample write, frame read and status signals of the FFT input buffer
interface fft_input_buffer_if
  import fft_pkg::*;
#(
  parameter int DW = DW_DEFAULT
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_cnt;
  logic [DW-1:0]     din_re;
  logic [DW-1:0]     din_im;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DW-1:0]     dout_re;
  logic [DW-1:0]     dout_im;
  logic              dout_valid;
  logic              frame_ready;
  logic              frame_done;
  logic              overrun;
  logic              overrun_sticky;

  modport master (
    output wr_en, wr_cnt, din_re, din_im, rd_addr, rd_en, frame_done,
    input  dout_re, dout_im, dout_valid, frame_ready, overrun, overrun_sticky
  );

  modport slave (
    input  wr_en, wr_cnt, din_re, din_im, rd_addr, rd_en, frame_done,
    output dout_re, dout_im, dout_valid, frame_ready, overrun, overrun_sticky
  );

endinterface

// File: rtl/fft_bank_ram.sv
// rtl/fft_bank_ram.sv - one 64-entry bank: single write port, registered read port that holds when idle
module fft_bank_ram
  import fft_pkg::*;
#(
  parameter int W = 2 * DW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem_q [NPT];
  logic [W-1:0] rdata_q;
  logic [W-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  // Only the output register is reset; array contents stay undefined.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fft_input_buffer.sv
// rtl/fft_input_buffer.sv - ping-pong frame store writing samples in bit-reversed order for the FFT core
module fft_input_buffer #(
  parameter int DW  = 16,
  parameter int NPT = 64
) (
  input logic               clk,
  input logic               rst,
  fft_input_buffer_if.slave bus
);
  import fft_pkg::*;

  if (NPT != fft_pkg::NPT) begin : g_npt_check
    $error("fft_input_buffer supports NPT=64 only");
  end

  rd_state_e state_q, state_d;
  logic wr_bank_q, wr_bank_d;
  logic overrun_q, overrun_d;
  logic sticky_q, sticky_d;
  logic dout_valid_q, dout_valid_d;
  logic rd_sel_q, rd_sel_d;

  logic              frame_complete;
  logic              frame_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [2*DW-1:0]   wdata;
  logic [2*DW-1:0]   rdata0;
  logic [2*DW-1:0]   rdata1;
  logic [2*DW-1:0]   rdata;

  assign frame_complete = bus.wr_en && (bus.wr_cnt == ADDR_W'(NPT - 1));
  assign frame_ready    = (state_q == RD_FULL);
  assign wr_addr        = bitrev6(bus.wr_cnt);
  assign wdata          = {bus.din_re, bus.din_im};

  // Writes go to wr_bank, reads to the other bank, so the two never collide.
  fft_bank_ram #(.W(2 * DW)) u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (bus.wr_en && !wr_bank_q),
    .waddr (wr_addr),
    .wdata (wdata),
    .re    (bus.rd_en && wr_bank_q),
    .raddr (bus.rd_addr),
    .rdata (rdata0)
  );

  fft_bank_ram #(.W(2 * DW)) u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (bus.wr_en && wr_bank_q),
    .waddr (wr_addr),
    .wdata (wdata),
    .re    (bus.rd_en && !wr_bank_q),
    .raddr (bus.rd_addr),
    .rdata (rdata1)
  );

  always_comb begin
    state_d      = state_q;
    wr_bank_d    = wr_bank_q;
    overrun_d    = 1'b0;
    sticky_d     = sticky_q;
    dout_valid_d = bus.rd_en && frame_ready;
    rd_sel_d     = bus.rd_en ? !wr_bank_q : rd_sel_q;

    unique case (state_q)
      RD_EMPTY: begin
        if (frame_complete) begin
          wr_bank_d = !wr_bank_q;
          state_d   = RD_FULL;
        end
      end
      RD_FULL: begin
        // A simultaneous release frees the held bank, so the new frame swaps in cleanly.
        if (frame_complete && bus.frame_done) begin
          wr_bank_d = !wr_bank_q;
        end else if (frame_complete) begin
          overrun_d = 1'b1;
          sticky_d  = 1'b1;
        end else if (bus.frame_done) begin
          state_d = RD_EMPTY;
        end
      end
      default: state_d = RD_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RD_EMPTY;
      wr_bank_q    <= 1'b0;
      overrun_q    <= 1'b0;
      sticky_q     <= 1'b0;
      dout_valid_q <= 1'b0;
      rd_sel_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_bank_q    <= wr_bank_d;
      overrun_q    <= overrun_d;
      sticky_q     <= sticky_d;
      dout_valid_q <= dout_valid_d;
      rd_sel_q     <= rd_sel_d;
    end
  end

  assign rdata              = rd_sel_q ? rdata1 : rdata0;
  assign bus.dout_re        = rdata[2*DW-1:DW];
  assign bus.dout_im        = rdata[DW-1:0];
  assign bus.dout_valid     = dout_valid_q;
  assign bus.frame_ready    = frame_ready;
  assign bus.overrun        = overrun_q;
  assign bus.overrun_sticky = sticky_q;

endmodule

// File: tb/tb_fft_input_buffer.sv
// tb/tb_fft_input_buffer.sv - self-checking bench for fft_input_buffer
module tb_fft_input_buffer;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fft_input_buffer_if #(.DW(DW)) bus_if ();

  fft_input_buffer #(.DW(DW), .NPT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic          valid;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } sb_entry_t;

  typedef struct {
    logic [5:0]    addr;
    logic [DW-1:0] exp_re;
  } rd_vec_t;

  sb_entry_t sb_q[$];
  rd_vec_t   vecs[8];
  int tests = 0;
  int fails = 0;

  function automatic logic [5:0] rev6(input logic [5:0] a);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[5-i] = a[i];
    return r;
  endfunction

  function automatic logic [DW-1:0] sample_re(input int fid, input int n);
    return DW'(fid * 64 + n);
  endfunction

  function automatic logic [DW-1:0] sample_im(input int fid, input int n);
    return DW'(-(fid * 64 + n));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock, drop strobes, and retire the read issued in the previous cycle.
  task automatic cycle();
    sb_entry_t e;
    @(posedge clk);
    #1;
    bus_if.wr_en      = 1'b0;
    bus_if.rd_en      = 1'b0;
    bus_if.frame_done = 1'b0;
    rst               = 1'b0;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("dout_valid", 32'(bus_if.dout_valid), 32'(e.valid));
      if (e.valid) begin
        check("dout_re", 32'(bus_if.dout_re), 32'(e.re));
        check("dout_im", 32'(bus_if.dout_im), 32'(e.im));
      end
    end
  endtask

  task automatic drive_read(input logic [5:0] addr, input logic exp_valid,
                            input logic [DW-1:0] re, input logic [DW-1:0] im);
    sb_entry_t e;
    bus_if.rd_en   = 1'b1;
    bus_if.rd_addr = addr;
    e.valid = exp_valid;
    e.re    = re;
    e.im    = im;
    sb_q.push_back(e);
  endtask

  task automatic read_frame(input int fid, input logic [5:0] addr);
    drive_read(addr, 1'b1, sample_re(fid, int'(rev6(addr))), sample_im(fid, int'(rev6(addr))));
    cycle();
  endtask

  // rd_fid >= 0 issues a random read each cycle expecting that frame in the read bank.
  task automatic write_samples(input int fid, input int lo, input int hi,
                               input bit done_last, input int rd_fid);
    logic [5:0] a;
    for (int n = lo; n <= hi; n++) begin
      bus_if.wr_en  = 1'b1;
      bus_if.wr_cnt = 6'(n);
      bus_if.din_re = sample_re(fid, n);
      bus_if.din_im = sample_im(fid, n);
      if (done_last && n == hi) bus_if.frame_done = 1'b1;
      if (rd_fid >= 0) begin
        a = 6'($urandom_range(0, 63));
        drive_read(a, 1'b1, sample_re(rd_fid, int'(rev6(a))), sample_im(rd_fid, int'(rev6(a))));
      end
      cycle();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{6'd1,  16'd32};
    vecs[1] = '{6'd6,  16'd24};
    vecs[2] = '{6'd0,  16'd0};
    vecs[3] = '{6'd63, 16'd63};
    vecs[4] = '{6'd2,  16'd16};
    vecs[5] = '{6'd32, 16'd1};
    vecs[6] = '{6'd5,  16'd40};
    vecs[7] = '{6'd48, 16'd3};

    rst               = 1'b1;
    bus_if.wr_en      = 1'b0;
    bus_if.wr_cnt     = '0;
    bus_if.din_re     = '0;
    bus_if.din_im     = '0;
    bus_if.rd_en      = 1'b0;
    bus_if.rd_addr    = '0;
    bus_if.frame_done = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_frame_ready", 32'(bus_if.frame_ready), 32'd0);
    check("rst_dout_valid",  32'(bus_if.dout_valid), 32'd0);
    check("rst_overrun",     32'(bus_if.overrun), 32'd0);
    check("rst_sticky",      32'(bus_if.overrun_sticky), 32'd0);
    check("rst_dout_re",     32'(bus_if.dout_re), 32'd0);
    check("rst_dout_im",     32'(bus_if.dout_im), 32'd0);

    // Empty-buffer reads and releases have no effect on status.
    drive_read(6'd0, 1'b0, '0, '0);
    cycle();
    bus_if.frame_done = 1'b1;
    cycle();
    check("empty_done_ready", 32'(bus_if.frame_ready), 32'd0);

    // Frame 0: natural-order fill, then table-driven bit-reversed reads.
    write_samples(0, 0, 62, 1'b0, -1);
    check("f0_ready_before_63", 32'(bus_if.frame_ready), 32'd0);
    write_samples(0, 63, 63, 1'b0, -1);
    check("f0_ready_after_63", 32'(bus_if.frame_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      drive_read(vecs[i].addr, 1'b1, vecs[i].exp_re, DW'(-vecs[i].exp_re));
      cycle();
    end
    cycle();
    check("dout_hold", 32'(bus_if.dout_re), 32'(vecs[7].exp_re));

    // Frame 1 completes while frame 0 is held: overrun, frame 0 still readable.
    write_samples(1, 0, 63, 1'b0, -1);
    check("ovr_pulse", 32'(bus_if.overrun), 32'd1);
    check("ovr_sticky", 32'(bus_if.overrun_sticky), 32'd1);
    check("ovr_ready", 32'(bus_if.frame_ready), 32'd1);
    cycle();
    check("ovr_pulse_end", 32'(bus_if.overrun), 32'd0);
    read_frame(0, 6'd3);
    read_frame(0, 6'd17);
    read_frame(0, 6'd40);
    bus_if.frame_done = 1'b1;
    cycle();
    check("release_ready", 32'(bus_if.frame_ready), 32'd0);
    bus_if.frame_done = 1'b1;
    cycle();
    check("empty_done_again", 32'(bus_if.frame_ready), 32'd0);
    write_samples(2, 0, 63, 1'b0, -1);
    check("f2_ready", 32'(bus_if.frame_ready), 32'd1);
    read_frame(2, 6'd1);
    read_frame(2, 6'd62);

    // Frame 3 completes in the same cycle as the release of frame 2.
    write_samples(3, 0, 63, 1'b1, 2);
    check("swap_no_overrun", 32'(bus_if.overrun), 32'd0);
    check("swap_ready", 32'(bus_if.frame_ready), 32'd1);
    read_frame(3, 6'd6);
    read_frame(3, 6'd33);

    // Frame 4 streams in while frame 3 is read every cycle.
    write_samples(4, 0, 63, 1'b0, 3);
    check("stream_overrun", 32'(bus_if.overrun), 32'd1);
    read_frame(3, 6'd9);
    read_frame(3, 6'd63);

    // Reset in the middle of frame 5, then a clean frame 6.
    write_samples(5, 0, 29, 1'b0, -1);
    bus_if.wr_en  = 1'b1;
    bus_if.wr_cnt = 6'd30;
    bus_if.din_re = sample_re(5, 30);
    bus_if.din_im = sample_im(5, 30);
    rst = 1'b1;
    cycle();
    check("midrst_ready", 32'(bus_if.frame_ready), 32'd0);
    check("midrst_sticky", 32'(bus_if.overrun_sticky), 32'd0);
    check("midrst_overrun", 32'(bus_if.overrun), 32'd0);
    write_samples(6, 0, 62, 1'b0, -1);
    check("f6_ready_before_63", 32'(bus_if.frame_ready), 32'd0);
    write_samples(6, 63, 63, 1'b0, -1);
    check("f6_ready", 32'(bus_if.frame_ready), 32'd1);
    check("f6_sticky", 32'(bus_if.overrun_sticky), 32'd0);
    for (int k = 0; k < 64; k++) begin
      read_frame(6, 6'(k));
    end

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
